// File: rtl/mem_1r1w_t1_resp.sv
// mem_1r1w_t1_resp
//   Behavioural memory end of the t1_* macro interface. It holds T1_NUMVROW rows
//   of T1_WIDTH bits. Port A does bit-masked writes. Port B returns read data
//   through a T1_DELAY-stage pipeline. After reset, an init sweep writes zero to
//   every row.
//
//   Optional build macro: MEM_1R1W_T1_COLL_CHK_EN
//     When defined, a same-cycle read and write to the same in-range row sets
//     t1_err. Data behaviour is the same in both builds.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous, active-low reset
//   t1_readB   read request
//   t1_addrB   read row address
//   t1_doutB   read data, updated T1_DELAY edges after the request
//   t1_writeA  write request
//   t1_addrA   write row address
//   t1_dinA    write data
//   t1_bwA     per-bit write enable (1 = write the bit)
//   init_done  high once the zeroing sweep has finished
//   t1_err     sticky protocol-error flag
//
// State     | meaning
// ----------+----------------------------------------------------
// IDLE_RST  | held in reset, or on the first edge after release
// INIT      | sweep writes zero to row[cnt], one row per cycle
// RUN       | normal read/write service

module mem_1r1w_t1_resp #(
  parameter int T1_WIDTH   = 15,
  parameter int T1_NUMVROW = 256,
  parameter int T1_BITVROW = 8,
  parameter int T1_DELAY   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  t1_readB,
  input  logic [T1_BITVROW-1:0] t1_addrB,
  output logic [T1_WIDTH-1:0]   t1_doutB,
  input  logic                  t1_writeA,
  input  logic [T1_BITVROW-1:0] t1_addrA,
  input  logic [T1_WIDTH-1:0]   t1_dinA,
  input  logic [T1_WIDTH-1:0]   t1_bwA,
  output logic                  init_done,
  output logic                  t1_err
);

  localparam int AW = (T1_NUMVROW > 1) ? $clog2(T1_NUMVROW) : 1;
  localparam logic [AW-1:0] LAST_ROW = AW'(T1_NUMVROW - 1);

  typedef enum logic [1:0] {IDLE_RST, INIT, RUN} state_t;

  state_t                state;
  logic [AW-1:0]         cnt;
  logic [T1_WIDTH-1:0]   mem [T1_NUMVROW];
  logic                  pipe_vld [T1_DELAY];
  logic [T1_WIDTH-1:0]   pipe_dat [T1_DELAY];

  logic                  run;
  logic                  rd_in_range;
  logic                  wr_in_range;
  logic                  collision;
  logic                  err_set;
  logic [AW-1:0]         rd_row;
  logic [AW-1:0]         wr_row;

  assign run         = (state == RUN);
  assign rd_in_range = int'(t1_addrB) < T1_NUMVROW;
  assign wr_in_range = int'(t1_addrA) < T1_NUMVROW;
  assign rd_row      = t1_addrB[AW-1:0];
  assign wr_row      = t1_addrA[AW-1:0];

`ifdef MEM_1R1W_T1_COLL_CHK_EN
  assign collision = run && t1_readB && t1_writeA && rd_in_range && (t1_addrA == t1_addrB);
`else
  assign collision = 1'b0;
`endif

  always_comb begin
    err_set = 1'b0;
    if (!run && (t1_readB || t1_writeA))    err_set = 1'b1;
    if (run && t1_readB && !rd_in_range)    err_set = 1'b1;
    if (run && t1_writeA && !wr_in_range)   err_set = 1'b1;
    if (collision)                          err_set = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE_RST;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        IDLE_RST: begin
          state <= INIT;
          cnt   <= '0;
        end
        INIT: begin
          if (cnt == LAST_ROW) begin
            state     <= RUN;
            init_done <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        RUN:     state <= RUN;
        default: state <= IDLE_RST;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) t1_err <= 1'b0;
    else if (err_set) t1_err <= 1'b1;
  end

  // The array has no reset. Only the sweep clears it. A row that is read and
  // written on the same edge returns its old contents, because the pipeline
  // samples mem before this block updates it.
  always_ff @(posedge clk) begin
    if (state == INIT) mem[cnt] <= '0;
    else if (run && t1_writeA && wr_in_range)
      mem[wr_row] <= (mem[wr_row] & ~t1_bwA) | (t1_dinA & t1_bwA);
  end

  // Every read request takes a slot, even an illegal one. An illegal read
  // carries zero, so it still overwrites t1_doutB on schedule.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < T1_DELAY; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_dat[i] <= '0;
      end
      t1_doutB <= '0;
    end else begin
      pipe_vld[0] <= t1_readB;
      pipe_dat[0] <= (t1_readB && run && rd_in_range) ? mem[rd_row] : '0;
      for (int i = 1; i < T1_DELAY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
      if (pipe_vld[T1_DELAY-1]) t1_doutB <= pipe_dat[T1_DELAY-1];
    end
  end

endmodule

// File: tb/tb_mem_1r1w_t1_resp.sv
// Testbench for mem_1r1w_t1_resp. The address width is set to 9 bits so that
// out-of-range rows (>= 256) can be requested.
module tb_mem_1r1w_t1_resp;

  localparam int W = 15;
  localparam int N = 256;
  localparam int B = 9;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd;
  logic [B-1:0] ra;
  logic [W-1:0] dout;
  logic         wr;
  logic [B-1:0] wa;
  logic [W-1:0] din;
  logic [W-1:0] bw;
  logic         init_done;
  logic         err;

  always #5 clk = ~clk;

  mem_1r1w_t1_resp #(
    .T1_WIDTH(W), .T1_NUMVROW(N), .T1_BITVROW(B), .T1_DELAY(D)
  ) dut (
    .clk(clk), .rst(rst),
    .t1_readB(rd), .t1_addrB(ra), .t1_doutB(dout),
    .t1_writeA(wr), .t1_addrA(wa), .t1_dinA(din), .t1_bwA(bw),
    .init_done(init_done), .t1_err(err)
  );

  int vecs = 0;
  int miss = 0;

  // Reference model: the row contents, plus a queue holding one slot per edge
  // for read results that are still in flight.
  logic [W-1:0] model [N];
  bit           qv [$];
  logic [W-1:0] qd [$];
  logic [W-1:0] exp_dout;
  bit           exp_err;
  int           e;   // rising edges seen since the last reset release

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vecs++;
    assert (got === expv) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic reset_model();
    qv = {};
    qd = {};
    for (int i = 0; i < D; i++) begin
      qv.push_back(1'b0);
      qd.push_back('0);
    end
    exp_dout = '0;
    exp_err  = 1'b0;
    e        = 0;
    for (int i = 0; i < N; i++) model[i] = '0;
  endtask

  task automatic step(input bit r, input int a_r, input bit w, input int a_w,
                      input logic [W-1:0] dn, input logic [W-1:0] b);
    bit           run_now;
    bit           v;
    logic [W-1:0] d;
    logic [B-1:0] ar;
    logic [B-1:0] aw;
    ar  = B'(a_r);
    aw  = B'(a_w);
    rd  = r;
    ra  = ar;
    wr  = w;
    wa  = aw;
    din = dn;
    bw  = b;
    // Edge 1 enters INIT and edges 2..N+1 sweep the rows, so requests are served from edge N+2 on.
    run_now = (e + 1 >= N + 2);
    d = '0;
    if (r && run_now && a_r < N) d = model[a_r];
    if ((r || w) && !run_now)    exp_err = 1'b1;
    if (run_now && r && a_r >= N) exp_err = 1'b1;
    if (run_now && w && a_w >= N) exp_err = 1'b1;
`ifdef MEM_1R1W_T1_COLL_CHK_EN
    if (run_now && r && w && a_r == a_w && a_r < N) exp_err = 1'b1;
`endif
    if (run_now && w && a_w < N) model[a_w] = (model[a_w] & ~b) | (dn & b);
    qv.push_back(r);
    qd.push_back(d);
    @(posedge clk);
    e++;
    v = qv.pop_front();
    d = qd.pop_front();
    if (v) exp_dout = d;
    #1;
    chk("doutB", 32'(dout), 32'(exp_dout));
    chk("err", 32'(err), 32'(exp_err));
    chk("init_done", 32'(init_done), (e >= N + 1) ? 32'd1 : 32'd0);
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 0, '0, '0);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    rd = 1'b0; wr = 1'b0; ra = '0; wa = '0; din = '0; bw = '0;
    #1;
    chk("rst_doutB", 32'(dout), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset_model();
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [W-1:0] rv;
    int a_r;
    int a_w;

    rst = 1'b0;
    rd = 1'b0; wr = 1'b0; ra = '0; wa = '0; din = '0; bw = '0;
    #3;
    chk("por_doutB", 32'(dout), 32'd0);
    chk("por_init_done", 32'(init_done), 32'd0);
    chk("por_err", 32'(err), 32'd0);
    reset_model();
    #4;
    rst = 1'b1;

    // Phase 1: accesses during INIT, then a reset in the middle of INIT.
    while (e < 59) idle();
    step(1'b1, 10, 1'b1, 30, 15'h7FFF, 15'h7FFF);
    chk("init_access_err", 32'(err), 32'd1);
    while (e < 102) idle();
    do_reset();

    // Phase 2: a full sweep, a write issued during INIT, then the basic directed tests.
    while (e < 255) begin
      if (e == 199) step(1'b0, 0, 1'b1, 30, 15'h7FFF, 15'h7FFF);
      else idle();
    end
    chk("init_write_err", 32'(err), 32'd1);
    idle();
    chk("init_done_edge256", 32'(init_done), 32'd0);
    idle();
    chk("init_done_edge257", 32'(init_done), 32'd1);

    step(1'b0, 0, 1'b1, 5, 15'h7FFF, 15'h7FFF);
    step(1'b0, 0, 1'b1, 5, 15'h0000, 15'h00FF);
    step(1'b1, 5, 1'b0, 0, '0, '0);
    idle();
    idle();
    chk("bw_merge_row5", 32'(dout), 32'h7F00);

    step(1'b1, 30, 1'b0, 0, '0, '0);
    idle();
    idle();
    chk("init_write_dropped", 32'(dout), 32'd0);

    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, i, W'(16 + i), 15'h7FFF);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) step(1'b1, i, 1'b0, 0, '0, '0);
      else idle();
      if (i >= 2) chk("b2b_read", 32'(dout), 32'(16 + i - 2));
    end

    step(1'b1, 200, 1'b0, 0, '0, '0);
    idle();
    idle();
    chk("swept_row200", 32'(dout), 32'd0);

    // This read is still in the pipeline when reset arrives, so it must not come out.
    step(1'b1, 5, 1'b0, 0, '0, '0);
    do_reset();

    // Phase 3: a read/write collision, an out-of-range read, then random traffic.
    while (e < 257) idle();
    step(1'b0, 0, 1'b1, 9, 15'h0AAA, 15'h7FFF);
    step(1'b1, 9, 1'b1, 9, 15'h1234, 15'h7FFF);
`ifdef MEM_1R1W_T1_COLL_CHK_EN
    chk("coll_err", 32'(err), 32'd1);
`else
    chk("coll_err", 32'(err), 32'd0);
`endif
    idle();
    idle();
    chk("coll_old_data", 32'(dout), 32'h0AAA);
    step(1'b1, 9, 1'b0, 0, '0, '0);
    idle();
    idle();
    chk("coll_write_done", 32'(dout), 32'h1234);

    step(1'b1, 300, 1'b0, 0, '0, '0);
    chk("oor_read_err", 32'(err), 32'd1);
    idle();
    idle();
    chk("oor_read_zero", 32'(dout), 32'd0);

    for (int i = 0; i < 400; i++) begin
      a_r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(256, 511)) : int'($urandom_range(0, 15));
      a_w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(256, 511)) : int'($urandom_range(0, 15));
      rv  = W'($urandom);
      step(1'($urandom_range(0, 1)), a_r, 1'($urandom_range(0, 1)), a_w, rv, W'($urandom));
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/mem_1r1w_t1_resp.md
# mem_1r1w_t1_resp

Behavioural responder for the single-port-per-direction T1 macro interface that the 1r1w top wraps drive. It stores T1_NUMVROW rows of T1_WIDTH bits, applies bit-masked writes on port A, and returns read data on port B after a fixed T1_DELAY-cycle pipeline. An init sequencer zeroes the array after reset. It serves as the memory end of the t1_* interface in simulation and formal benches.

## Interface
- T1_WIDTH, 15, data width in bits.
- T1_NUMVROW, 256, number of rows.
- T1_BITVROW, 8, address width.
- T1_DELAY, 2, read latency in cycles; legal range 1..8.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- t1_readB  input  1  read request.
- t1_addrB  input  T1_BITVROW  read row address.
- t1_doutB  output  T1_WIDTH  read data, valid T1_DELAY cycles after the request.
- t1_writeA  input  1  write request.
- t1_addrA  input  T1_BITVROW  write row address.
- t1_dinA  input  T1_WIDTH  write data.
- t1_bwA  input  T1_WIDTH  per-bit write enable; 1 means the bit is written.
- init_done  output  1  high once the post-reset zeroing sweep has finished.
- t1_err  output  1  sticky protocol-error flag.

## Operation
- FSM states are IDLE_RST, INIT and RUN.
  - rst low forces IDLE_RST asynchronously.
  - The first clk edge with rst high moves to INIT with the sweep counter at 0.
  - INIT writes all-zero to row[counter] and increments once per cycle.
  - When the counter reaches T1_NUMVROW-1, that row is written and the FSM moves to RUN.
  - RUN persists until rst is asserted.
- The array itself is not asynchronously reset; only the sweep clears it.
- Reset values: t1_doutB=0, init_done=0, t1_err=0, read pipeline valid and data stages all 0.
- Write (RUN, t1_writeA=1, t1_addrA<T1_NUMVROW): row <= (row & ~t1_bwA) | (t1_dinA & t1_bwA). With bw=0 the row is unchanged.
- Read (RUN, t1_readB=1, t1_addrB<T1_NUMVROW): the row is sampled at the request edge and shifted through T1_DELAY stages.
- Read/write collision to the same address in the same cycle: the read returns the old (pre-write) data and the write still completes.
- Out-of-range address (>= T1_NUMVROW):
  - write is dropped;
  - read returns 0 after T1_DELAY cycles;
  - t1_err is set.
- Any t1_readB or t1_writeA while not in RUN:
  - the access is ignored;
  - a read returns 0 at its slot;
  - t1_err is set.
- t1_doutB holds its last value when no read completes in a cycle.
- t1_err clears only on reset.
- Reset asserted mid-INIT or mid-read: the pipeline and FSM clear immediately, and the sweep restarts from row 0 after release.

## Timing
- Read latency: request at edge N, data on t1_doutB after edge N+T1_DELAY.
- Back-to-back reads every cycle are supported; the pipeline is fully pipelined.
- Write latency: a write at edge N is visible to a read requested at edge N+1 or later.
- init_done rises on the edge that writes row T1_NUMVROW-1. The first edge after rst release is edge 1 (the transition to INIT), so init_done rises at edge T1_NUMVROW+1, i.e. T1_NUMVROW+1 edges after release.
- t1_err asserts on the edge following the offending request.

## Configuration
- Macro: MEM_1R1W_T1_COLL_CHK_EN.
- Defined: a same-cycle read and write to the same in-range address in RUN also sets t1_err. Data behaviour is unchanged (the read still returns old data).
- Undefined: collisions are legal and never flag. All other t1_err sources remain active.

## Test plan
- Reset release with T1_NUMVROW=256: init_done is 0 until edge 257, then 1. A read of row 200 then returns 0 after 2 cycles.
- Write row 5, din=0x7FFF, bw=0x7FFF; next cycle write row 5, din=0x0000, bw=0x00FF; then read row 5 -> 0x7F00 appears T1_DELAY cycles later.
- Same cycle: write row 9 = 0x1234 (full bw) while reading row 9, with prior content 0x0AAA -> read returns 0x0AAA; a later read returns 0x1234. t1_err is 1 only with MEM_1R1W_T1_COLL_CHK_EN defined.
- Continuous reads of rows 0,1,2,3 over consecutive cycles (rows preloaded with 0x10..0x13) -> t1_doutB shows 0x10,0x11,0x12,0x13 on consecutive cycles starting T1_DELAY after the first request.
- Read with t1_addrB=300 when T1_NUMVROW=256 -> t1_doutB=0 at its slot and t1_err=1. A write issued during INIT also sets t1_err, and the target row stays 0.
- Assert rst mid-INIT at row 100, then release -> t1_doutB=0, init_done=0, and the sweep restarts at row 0, completing T1_NUMVROW+1 edges after release.
